// File: rtl/bru_pipe_if.sv
// Request/response bundle for bru_pipe: request fields, registered branch result,
// flush control and the side-band BHT lookup port.
interface bru_pipe_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic [XLEN-1:0] imm;
  logic [7:0]      bru_op;
  logic            pred_taken;
  logic [XLEN-1:0] pred_addr;

  logic            out_valid;
  logic            out_ready;
  logic            br_e;
  logic [XLEN-1:0] br_addr;
  logic [XLEN-1:0] br_result;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;

  logic            flush;
  logic [XLEN-1:0] bht_pc;
  logic            bht_taken;

  modport master (
    output in_valid, pc, rdata1, rdata2, imm, bru_op, pred_taken, pred_addr,
    output out_ready, flush, bht_pc,
    input  in_ready, out_valid, br_e, br_addr, br_result, mispredict, redirect_pc,
    input  bht_taken
  );

  modport slave (
    input  in_valid, pc, rdata1, rdata2, imm, bru_op, pred_taken, pred_addr,
    input  out_ready, flush, bht_pc,
    output in_ready, out_valid, br_e, br_addr, br_result, mispredict, redirect_pc,
    output bht_taken
  );
endinterface

// File: rtl/bru_pipe.sv
// Single-stage branch resolution unit with valid/ready result register.
// Optional 2-bit branch history table enabled by defining BRU_BHT_EN.
module bru_pipe #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned BHT_DEPTH = 64
) (
  input logic    clock,
  input logic    reset_n,
  bru_pipe_if.slave bus
);

  // bru_op one-hot positions, MSB first
  localparam int unsigned OP_JAL  = 7;
  localparam int unsigned OP_JALR = 6;

  logic            in_ready;
  logic            capture;
  logic            xfer;

  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] rs1_imm;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] link;
  logic            op_eq;
  logic            op_lt_s;
  logic            op_lt_u;

  logic            taken;
  logic            is_cond;
  logic [XLEN-1:0] target;
  logic            mis;
  logic [XLEN-1:0] redirect;

  logic            out_valid_q;
  logic            br_e_q;
  logic [XLEN-1:0] br_addr_q;
  logic [XLEN-1:0] br_result_q;
  logic            mispredict_q;
  logic [XLEN-1:0] redirect_q;
  logic            cond_q;

  assign in_ready = ~out_valid_q | bus.out_ready;
  assign capture  = bus.in_valid & in_ready & ~bus.flush;
  assign xfer     = out_valid_q & bus.out_ready & ~bus.flush;

  assign pc_imm      = bus.pc + bus.imm;
  assign rs1_imm     = bus.rdata1 + bus.imm;
  assign jalr_target = {rs1_imm[XLEN-1:1], 1'b0};
  assign link        = bus.pc + XLEN'(4);

  assign op_eq   = (bus.rdata1 == bus.rdata2);
  assign op_lt_s = ($signed(bus.rdata1) < $signed(bus.rdata2));
  assign op_lt_u = (bus.rdata1 < bus.rdata2);

  // Highest set op bit wins; an empty op resolves as not-taken with a zero target.
  always_comb begin
    taken   = 1'b0;
    is_cond = 1'b0;
    target  = '0;
    casez (bus.bru_op)
      8'b1???????: begin taken = 1'b1;     target = pc_imm;      end
      8'b01??????: begin taken = 1'b1;     target = jalr_target; end
      8'b001?????: begin taken = op_eq;    target = pc_imm; is_cond = 1'b1; end
      8'b0001????: begin taken = ~op_eq;   target = pc_imm; is_cond = 1'b1; end
      8'b00001???: begin taken = op_lt_s;  target = pc_imm; is_cond = 1'b1; end
      8'b000001??: begin taken = ~op_lt_s; target = pc_imm; is_cond = 1'b1; end
      8'b0000001?: begin taken = op_lt_u;  target = pc_imm; is_cond = 1'b1; end
      8'b00000001: begin taken = ~op_lt_u; target = pc_imm; is_cond = 1'b1; end
      default:     begin taken = 1'b0;     target = '0;     end
    endcase
  end

  always_comb begin
    mis      = (taken != bus.pred_taken)
             | (taken & bus.pred_taken & (target != bus.pred_addr));
    redirect = taken ? target : link;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      br_e_q       <= 1'b0;
      br_addr_q    <= '0;
      br_result_q  <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      cond_q       <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q  <= 1'b0;
    end else if (capture) begin
      out_valid_q  <= 1'b1;
      br_e_q       <= taken;
      br_addr_q    <= target;
      br_result_q  <= link;
      mispredict_q <= mis;
      redirect_q   <= redirect;
      cond_q       <= is_cond;
    end else if (bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.br_e        = br_e_q;
  assign bus.br_addr     = br_addr_q;
  assign bus.br_result   = br_result_q;
  assign bus.mispredict  = mispredict_q;
  assign bus.redirect_pc = redirect_q;

`ifdef BRU_BHT_EN
  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] hold_idx;
  logic [IDX_W-1:0] look_idx;
  logic             bht_upd;
  logic             unused_bht;

  assign look_idx   = bus.bht_pc[IDX_W+1:2];
  assign bht_upd    = xfer & cond_q;
  assign unused_bht = ^{bus.bht_pc[XLEN-1:IDX_W+2], bus.bht_pc[1:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_idx <= '0;
    end else if (capture) begin
      hold_idx <= bus.pc[IDX_W+1:2];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= 2'd1;
      end
    end else if (bht_upd) begin
      if (br_e_q && bht[hold_idx] != 2'd3) begin
        bht[hold_idx] <= bht[hold_idx] + 2'd1;
      end else if (!br_e_q && bht[hold_idx] != 2'd0) begin
        bht[hold_idx] <= bht[hold_idx] - 2'd1;
      end
    end
  end

  // Registered table: a same-cycle update is only visible from the next cycle.
  assign bus.bht_taken = bht[look_idx][1];
`else
  logic unused_bht;

  assign unused_bht    = ^{bus.bht_pc, xfer, cond_q};
  assign bus.bht_taken = 1'b0;
`endif

endmodule

// File: tb/tb_bru_pipe.sv
// Directed bench for bru_pipe: vector table through a sustained pipeline, then
// stall, reset-pulse, flush and BHT sequences (BHT expectations follow BRU_BHT_EN).
module tb_bru_pipe;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned BHT_DEPTH = 64;
`ifdef BRU_BHT_EN
  localparam logic BHT_ON = 1'b1;
`else
  localparam logic BHT_ON = 1'b0;
`endif

  localparam logic [7:0] JAL  = 8'h80;
  localparam logic [7:0] JALR = 8'h40;
  localparam logic [7:0] BEQ  = 8'h20;
  localparam logic [7:0] BNE  = 8'h10;
  localparam logic [7:0] BLT  = 8'h08;
  localparam logic [7:0] BGE  = 8'h04;
  localparam logic [7:0] BLTU = 8'h02;
  localparam logic [7:0] BGEU = 8'h01;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [7:0]  op;
    logic [63:0] pc;
    logic [63:0] r1;
    logic [63:0] r2;
    logic [63:0] imm;
    logic        pt;
    logic [63:0] pa;
    logic        e;
    logic [63:0] addr;
    logic [63:0] res;
    logic        mis;
    logic [63:0] redir;
  } vec_t;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  bru_pipe_if #(.XLEN(XLEN)) bus ();

  bru_pipe #(.XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  vec_t vecs[15];
  vec_t bne_t;
  vec_t bne_nt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.bru_op     = v.op;
    bus.pc         = v.pc;
    bus.rdata1     = v.r1;
    bus.rdata2     = v.r2;
    bus.imm        = v.imm;
    bus.pred_taken = v.pt;
    bus.pred_addr  = v.pa;
  endtask

  task automatic check_out(input vec_t v, input string tag);
    chk({tag, ".out_valid"},   64'(bus.out_valid),  64'd1);
    chk({tag, ".br_e"},        64'(bus.br_e),       64'(v.e));
    chk({tag, ".br_addr"},     bus.br_addr,         v.addr);
    chk({tag, ".br_result"},   bus.br_result,       v.res);
    chk({tag, ".mispredict"},  64'(bus.mispredict), 64'(v.mis));
    chk({tag, ".redirect_pc"}, bus.redirect_pc,     v.redir);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".out_valid"},   64'(bus.out_valid),  64'd0);
    chk({tag, ".br_e"},        64'(bus.br_e),       64'd0);
    chk({tag, ".mispredict"},  64'(bus.mispredict), 64'd0);
    chk({tag, ".br_addr"},     bus.br_addr,         64'd0);
    chk({tag, ".br_result"},   bus.br_result,       64'd0);
    chk({tag, ".redirect_pc"}, bus.redirect_pc,     64'd0);
    chk({tag, ".in_ready"},    64'(bus.in_ready),   64'd1);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           op     pc                     r1                     r2     imm                    pt    pa                     e     addr                   res                    mis   redir
    vecs[0]  = '{BEQ,   64'h1000,              64'd5,                 64'd5, 64'h20,                1'b0, 64'h0,                 1'b1, 64'h1020,              64'h1004,              1'b1, 64'h1020};
    vecs[1]  = '{JALR,  64'h2000,              64'hFFFF_FFFF_0000_0003, 64'd0, 64'h0,               1'b1, 64'hFFFF_FFFF_0000_0002, 1'b1, 64'hFFFF_FFFF_0000_0002, 64'h2004,          1'b0, 64'hFFFF_FFFF_0000_0002};
    vecs[2]  = '{BLT,   64'h3000,              ONES,                  64'd1, 64'h10,                1'b1, 64'h3010,              1'b1, 64'h3010,              64'h3004,              1'b0, 64'h3010};
    vecs[3]  = '{BLTU,  64'h3000,              ONES,                  64'd1, 64'h10,                1'b1, 64'h3010,              1'b0, 64'h3010,              64'h3004,              1'b1, 64'h3004};
    vecs[4]  = '{8'h00, 64'h4000,              64'd1,                 64'd2, 64'h44,                1'b1, 64'h4044,              1'b0, 64'h0,                 64'h4004,              1'b1, 64'h4004};
    vecs[5]  = '{8'h00, 64'h4000,              64'd1,                 64'd2, 64'h44,                1'b0, 64'h4044,              1'b0, 64'h0,                 64'h4004,              1'b0, 64'h4004};
    vecs[6]  = '{JAL,   64'hFFFF_FFFF_FFFF_FFFC, 64'd0,               64'd0, 64'h8,                 1'b1, 64'h8,                 1'b1, 64'h4,                 64'h0,                 1'b1, 64'h4};
    vecs[7]  = '{8'hA0, 64'h100,               64'd1,                 64'd2, 64'h40,                1'b0, 64'h0,                 1'b1, 64'h140,               64'h104,               1'b1, 64'h140};
    vecs[8]  = '{BGE,   64'h500,               64'd1,                 ONES,  64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'h4FC,             1'b1, 64'h4FC,               64'h504,               1'b0, 64'h4FC};
    vecs[9]  = '{BGEU,  64'h500,               64'd1,                 ONES,  64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0,               1'b0, 64'h4FC,               64'h504,               1'b0, 64'h504};
    vecs[10] = '{BNE,   64'h600,               64'd7,                 64'd7, 64'h8,                 1'b0, 64'h0,                 1'b0, 64'h608,               64'h604,               1'b0, 64'h604};
    vecs[11] = '{BGEU,  64'h700,               64'd9,                 64'd9, 64'h100,               1'b1, 64'h900,               1'b1, 64'h800,               64'h704,               1'b1, 64'h800};
    vecs[12] = '{JALR,  64'h20,                64'h1001,              64'd0, 64'h10,                1'b0, 64'h0,                 1'b1, 64'h1010,              64'h24,                1'b1, 64'h1010};
    vecs[13] = '{8'h1F, 64'h800,               64'd3,                 64'd3, 64'h20,                1'b0, 64'h0,                 1'b0, 64'h820,               64'h804,               1'b0, 64'h804};
    vecs[14] = '{BEQ,   64'h900,               64'd5,                 64'd6, 64'h10,                1'b1, 64'h910,               1'b0, 64'h910,               64'h904,               1'b1, 64'h904};
    bne_t    = '{BNE,   64'h40,                64'd1,                 64'd2, 64'h10,                1'b1, 64'h50,                1'b1, 64'h50,                64'h44,                1'b0, 64'h50};
    bne_nt   = '{BNE,   64'h40,                64'd4,                 64'd4, 64'h10,                1'b0, 64'h0,                 1'b0, 64'h50,                64'h44,                1'b0, 64'h44};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b0;
    bus.bht_pc    = 64'h40;
    drive(vecs[0]);

    #1;
    check_zero("reset");
    chk("reset.bht_taken", 64'(bus.bht_taken), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset_held");
    reset_n = 1'b1;
    #1;
    chk("post_reset.in_ready", 64'(bus.in_ready), 64'd1);

    // Vector table at one request per cycle.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i]);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk($sformatf("vec%0d.in_ready", i), 64'(bus.in_ready), 64'd1);
      tick();
      check_out(vecs[i], $sformatf("vec%0d", i));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("drain.out_valid", 64'(bus.out_valid), 64'd0);

    // Back-pressure: result held for three cycles, then back-to-back accepts.
    drive(vecs[0]);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    check_out(vecs[0], "stall_first");
    drive(vecs[1]);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d.in_ready", c), 64'(bus.in_ready), 64'd0);
      tick();
      check_out(vecs[0], $sformatf("stall%0d", c));
    end
    bus.out_ready = 1'b1;
    #1;
    chk("unstall.in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    check_out(vecs[1], "b2b_0");
    drive(vecs[2]);
    tick();
    check_out(vecs[2], "b2b_1");

    // Asynchronous reset while a result is held.
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("midreset");
    tick();
    reset_n = 1'b1;
    #1;
    check_zero("after_midreset");

    // Flush drops the held result and the same-cycle request, BHT untouched.
    drive(bne_t);
    bus.bht_pc    = 64'h40;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check_out(bne_t, "pre_flush");
    bus.flush = 1'b1;
    tick();
    chk("flush.out_valid", 64'(bus.out_valid), 64'd0);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("flush.bht_taken", 64'(bus.bht_taken), 64'd0);
    tick();
    chk("flush_idle.out_valid", 64'(bus.out_valid), 64'd0);

    // Three taken bne transfers: lookup sees the pre-update counter each time.
    bus.in_valid = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bht_up%0d.bht_taken", k), 64'(bus.bht_taken),
          (k == 0) ? 64'd0 : 64'(BHT_ON));
      if (k == 2) bus.in_valid = 1'b0;
      tick();
    end
    chk("bht_up.out_valid", 64'(bus.out_valid), 64'd0);
    chk("bht_0x40.bht_taken", 64'(bus.bht_taken), 64'(BHT_ON));
    bus.bht_pc = 64'h140;
    #1;
    chk("bht_0x140.bht_taken", 64'(bus.bht_taken), 64'(BHT_ON));
    bus.bht_pc = 64'h44;
    #1;
    chk("bht_0x44.bht_taken", 64'(bus.bht_taken), 64'd0);

    // Two not-taken transfers walk the saturated counter back down to 1.
    bus.bht_pc = 64'h40;
    drive(bne_nt);
    bus.in_valid = 1'b1;
    tick();
    check_out(bne_nt, "bht_dn0");
    tick();
    check_out(bne_nt, "bht_dn1");
    chk("bht_dn1.bht_taken", 64'(bus.bht_taken), 64'(BHT_ON));
    bus.in_valid = 1'b0;
    tick();
    chk("bht_dn2.bht_taken", 64'(bus.bht_taken), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
